turn_controller: RTL

Game-sequencing controller for the chess clock. It decides which player's Timer_Clock counts down, and gates the two timers' IMPULSE enables from the player-switch (SELECT), pause (STOP) and new-game (START) buttons. It detects flag-fall from the timers' OVERFLOW outputs, latches the loser, and counts completed moves. It replaces the simple Switch/Overflow_Handler pair at top level.

---
 rtl/turn_controller.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/turn_controller.sv
// Chess-clock turn sequencer: conditions START/SELECT/STOP, runs the player FSM,
// latches the flagged player and counts moves. Optional input filter: TURN_CTRL_DEBOUNCE_EN.
module turn_controller #(
  parameter int MOVE_W          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              START,
  input  logic              SELECT,
  input  logic              STOP,
  input  logic              OVERFLOW1,
  input  logic              OVERFLOW2,
  output logic              Enable_p1,
  output logic              Enable_p2,
  output logic              END,
  output logic [1:0]        LOSER,
  output logic [MOVE_W-1:0] MOVES,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN_P1 = 3'd1,
    S_RUN_P2 = 3'd2,
    S_PAUSE  = 3'd3,
    S_OVER   = 3'd4
  } state_e;

  // Bit order {STOP, SELECT, START}. The button channels reset high so a
  // button still held when reset releases never looks like a fresh press.
  localparam logic [2:0] SYNC_RST = 3'b011;

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] lvl_s;
  logic [1:0] prev_q;
  logic       start_press_s;
  logic       select_press_s;
  logic       stop_s;
  logic       overflow_s;

  // Two-flop synchronizers, free-running on every clock
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {STOP, SELECT, START};
      sync2_q <= sync1_q;
    end
  end

`ifdef TURN_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       filt_q;
  logic [2:0]       filt_d;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounce state, advanced on CE only
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      filt_q <= SYNC_RST;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else if (CE) begin
      filt_q <= filt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign lvl_s = filt_q;
`else
  logic db_unused_s;
  assign db_unused_s = (DEBOUNCE_CYCLES > 0);
  assign lvl_s       = sync2_q;
`endif

  // Rising-edge history for START and SELECT
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      prev_q <= SYNC_RST[1:0];
    end else if (CE) begin
      prev_q <= lvl_s[1:0];
    end
  end

  assign start_press_s  = CE & lvl_s[0] & ~prev_q[0];
  assign select_press_s = CE & lvl_s[1] & ~prev_q[1];
  assign stop_s         = lvl_s[2];
  assign overflow_s     = OVERFLOW1 | OVERFLOW2;

  state_e            state_q, state_d;
  logic              resume_q, resume_d;
  logic [MOVE_W-1:0] moves_q, moves_d, moves_inc_s;
  logic [1:0]        loser_q, loser_d;
  logic              en1_q, en2_q, end_q;

  assign moves_inc_s = (&moves_q) ? moves_q : moves_q + MOVE_W'(1);

  // Next-state decode; priority OVERFLOW > STOP > START > SELECT
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    moves_d  = moves_q;
    loser_d  = loser_q;
    case (state_q)
      S_IDLE: begin
        if (start_press_s && !stop_s) begin
          state_d = S_RUN_P1;
          moves_d = '0;
          loser_d = 2'b00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN_P1: begin
        if (overflow_s) begin
          state_d = S_OVER;
          loser_d = {OVERFLOW2, OVERFLOW1};
        end else if (stop_s) begin
          state_d  = S_PAUSE;
          resume_d = 1'b0;
        end else if (select_press_s) begin
          state_d = S_RUN_P2;
          moves_d = moves_inc_s;
        end else begin
          state_d = S_RUN_P1;
        end
      end
      S_RUN_P2: begin
        if (overflow_s) begin
          state_d = S_OVER;
          loser_d = {OVERFLOW2, OVERFLOW1};
        end else if (stop_s) begin
          state_d  = S_PAUSE;
          resume_d = 1'b1;
        end else if (select_press_s) begin
          state_d = S_RUN_P1;
          moves_d = moves_inc_s;
        end else begin
          state_d = S_RUN_P2;
        end
      end
      S_PAUSE: begin
        if (overflow_s) begin
          state_d = S_OVER;
          loser_d = {OVERFLOW2, OVERFLOW1};
        end else if (!stop_s) begin
          state_d = resume_q ? S_RUN_P2 : S_RUN_P1;
        end else if (start_press_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_OVER: begin
        if (start_press_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs decoded from the next state
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= S_IDLE;
      resume_q <= 1'b0;
      moves_q  <= '0;
      loser_q  <= 2'b00;
      en1_q    <= 1'b0;
      en2_q    <= 1'b0;
      end_q    <= 1'b0;
    end else if (CE) begin
      state_q  <= state_d;
      resume_q <= resume_d;
      moves_q  <= moves_d;
      loser_q  <= loser_d;
      en1_q    <= (state_d == S_RUN_P1);
      en2_q    <= (state_d == S_RUN_P2);
      end_q    <= (state_d == S_OVER);
    end
  end

  assign Enable_p1 = en1_q;
  assign Enable_p2 = en2_q;
  assign END       = end_q;
  assign LOSER     = loser_q;
  assign MOVES     = moves_q;
  assign STATE     = state_q;

endmodule
